// File: rtl/nfc_pkg.sv
// Shared definitions for the NAND flash copy controller and NAND flash target.
// Contents:
//   CMD_*        ONFI-style opcodes understood by the target
//   nfc_state_t  target FSM state encoding (also exported on o_dbg_state)
package nfc_pkg;

    localparam logic [7:0] CMD_READ    = 8'h00;
    localparam logic [7:0] CMD_PROG    = 8'h80;
    localparam logic [7:0] CMD_CONFIRM = 8'h10;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_LOAD = 3'd2,
        ST_RD_OUT  = 3'd3,
        ST_PG_ADDR = 3'd4,
        ST_PG_IN   = 3'd5,
        ST_PG_BUSY = 3'd6
    } nfc_state_t;

endpackage

// File: rtl/nft_page_buf.sv
// Page register of the NAND flash target: single-clock DEPTH x 8 RAM.
// Ports:
//   clk, rst    clock; async active-high reset (clears only the sync read register)
//   i_we        write enable, i_waddr / i_wdata write address and data
//   i_araddr    async read address  -> o_ardata (same cycle, feeds F_IO)
//   i_sraddr    sync read address   -> o_srdata (one cycle later, feeds the array)
module nft_page_buf #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_araddr,
    output logic [7:0]    o_ardata,
    input  logic [AW-1:0] i_sraddr,
    output logic [7:0]    o_srdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_srdata;

    // Contents survive reset on purpose: an aborted operation keeps the page.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_srdata <= '0;
        end else begin
            r_srdata <= r_mem[i_sraddr];
        end
    end

    assign o_ardata = r_mem[i_araddr];
    assign o_srdata = r_srdata;

endmodule

// File: rtl/nand_flash_target.sv
// NAND flash target: decodes the CLE/ALE/WEN/REN pin stream, owns a page
// register, and moves whole pages to/from an external array memory.
// Ports:
//   clk, rst      clock; async active-high reset
//   F_IO          bidirectional bus, driven only in RD_OUT while F_REN=0
//   F_CLE/F_ALE   command / address latch enables, sampled on a WEN rise
//   F_WEN         write strobe (byte latched on 0->1)
//   F_REN         read strobe (byte driven while low, column advances on 0->1)
//   F_RB          1 = ready, 0 = busy
//   arr_addr      {page, col} into the array; arr_wdata/arr_we write port
//   arr_rdata     array read data, valid one cycle after arr_addr
//   o_dbg_state   current FSM state; o_dbg_io_oe F_IO output enable
// Handshake: the host may only issue a strobe edge while F_RB=1; every edge
// seen while F_RB=0 is dropped, so the busy flag is the sole flow control.
module nand_flash_target
    import nfc_pkg::*;
#(
    parameter int PAGE_BYTES   = 512,
    parameter int PAGE_AW      = 9,
    parameter int T_R_EXTRA    = 8,
    parameter int T_PROG_EXTRA = 16,
    localparam int COL_AW      = $clog2(PAGE_BYTES)
) (
    input  logic                      clk,
    input  logic                      rst,
    inout  wire  [7:0]                F_IO,
    input  logic                      F_CLE,
    input  logic                      F_ALE,
    input  logic                      F_WEN,
    input  logic                      F_REN,
    output logic                      F_RB,
    output logic [PAGE_AW+COL_AW-1:0] arr_addr,
    output logic [7:0]                arr_wdata,
    output logic                      arr_we,
    input  logic [7:0]                arr_rdata,
    output nfc_state_t                o_dbg_state,
    output logic                      o_dbg_io_oe
);

    localparam int CNT_W = $clog2(PAGE_BYTES + T_R_EXTRA + T_PROG_EXTRA + 1);
    localparam logic [CNT_W-1:0] C_PAGE   = CNT_W'(PAGE_BYTES);
    localparam logic [CNT_W-1:0] C_LD_END = CNT_W'(PAGE_BYTES + T_R_EXTRA);
    localparam logic [CNT_W-1:0] C_PG_END = CNT_W'(PAGE_BYTES + T_PROG_EXTRA - 1);
    localparam logic [CNT_W-1:0] C_CNT_1  = CNT_W'(1);
    localparam logic [COL_AW:0]  C_COL_1  = (COL_AW+1)'(1);
    localparam logic [2:0]       C_HOLD   = 3'd4;

    nfc_state_t r_state, w_state_nxt;

    logic                r_wen_q, r_ren_q;
    logic                r_rb;
    logic [2:0]          r_hold;
    logic [CNT_W-1:0]    r_cnt;
    logic [COL_AW:0]     r_col;          // extra MSB marks "past the last column"
    logic [PAGE_AW-1:0]  r_page;
    logic [1:0]          r_addr_cnt;
    logic                r_ld_vld;
    logic [COL_AW-1:0]   r_ld_col;
    logic                r_arr_we;
    logic [COL_AW-1:0]   r_prog_col;

    logic [7:0]          w_io_in;
    logic                w_wen_rise, w_ren_rise;
    logic                w_cmd, w_adr, w_dat;
    logic                w_cmd_reset, w_adr_take, w_addr_last;
    logic                w_enter_load, w_enter_prog;
    logic                w_ld_done, w_pg_done, w_pg_wr;
    logic                w_io_oe;
    logic                w_buf_we;
    logic [COL_AW-1:0]   w_buf_waddr;
    logic [7:0]          w_buf_wdata, w_buf_ardata, w_buf_srdata;

    assign w_io_in = F_IO;

    // Edges compare the raw pin with its registered copy; busy masks them.
    assign w_wen_rise = F_WEN & ~r_wen_q & r_rb;
    assign w_ren_rise = F_REN & ~r_ren_q & r_rb;

    assign w_cmd = w_wen_rise &  F_CLE & ~F_ALE;
    assign w_adr = w_wen_rise & ~F_CLE &  F_ALE;
    assign w_dat = w_wen_rise & ~F_CLE & ~F_ALE;

    assign w_cmd_reset  = w_cmd && (w_io_in == CMD_RESET);
    assign w_adr_take   = w_adr && (r_state == ST_RD_ADDR || r_state == ST_PG_ADDR)
                          && (r_addr_cnt != 2'd3);
    assign w_addr_last  = w_adr_take && (r_addr_cnt == 2'd2);
    assign w_enter_load = w_addr_last && (r_state == ST_RD_ADDR);
    assign w_enter_prog = w_cmd && (w_io_in == CMD_CONFIRM) && (r_state == ST_PG_IN);
    assign w_ld_done    = (r_state == ST_RD_LOAD) && (r_cnt == C_LD_END);
    assign w_pg_done    = (r_state == ST_PG_BUSY) && (r_cnt == C_PG_END);
    assign w_pg_wr      = w_dat && (r_state == ST_PG_IN) && !r_col[COL_AW];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_cmd) begin
            // Any command is legal from any ready state; unknown ones park in IDLE.
            case (w_io_in)
                CMD_READ:    w_state_nxt = ST_RD_ADDR;
                CMD_PROG:    w_state_nxt = ST_PG_ADDR;
                CMD_CONFIRM: w_state_nxt = (r_state == ST_PG_IN) ? ST_PG_BUSY : ST_IDLE;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end else begin
            case (r_state)
                ST_RD_ADDR: if (w_addr_last) w_state_nxt = ST_RD_LOAD;
                ST_PG_ADDR: if (w_addr_last) w_state_nxt = ST_PG_IN;
                ST_RD_LOAD: if (w_ld_done)   w_state_nxt = ST_RD_OUT;
                ST_PG_BUSY: if (w_pg_done)   w_state_nxt = ST_IDLE;
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_io_oe  = (r_state == ST_RD_OUT) && !F_REN;
        arr_addr = '0;
        if (r_state == ST_RD_LOAD) begin
            arr_addr = {r_page, r_cnt[COL_AW-1:0]};
        end else if (r_arr_we) begin
            arr_addr = {r_page, r_prog_col};
        end
    end

    assign F_IO        = w_io_oe ? w_buf_ardata : 8'bz;
    assign F_RB        = r_rb;
    assign arr_we      = r_arr_we;
    assign arr_wdata   = w_buf_srdata;
    assign o_dbg_state = r_state;
    assign o_dbg_io_oe = w_io_oe;

    // ---------------- counters, address and column registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen_q    <= 1'b1;
            r_ren_q    <= 1'b1;
            r_rb       <= 1'b1;
            r_hold     <= '0;
            r_cnt      <= '0;
            r_col      <= '0;
            r_page     <= '0;
            r_addr_cnt <= '0;
            r_ld_vld   <= 1'b0;
            r_ld_col   <= '0;
            r_arr_we   <= 1'b0;
            r_prog_col <= '0;
        end else begin
            r_wen_q <= F_WEN;
            r_ren_q <= F_REN;

            if (w_enter_load || w_enter_prog) begin
                r_rb <= 1'b0;
            end else if (w_ld_done || w_pg_done) begin
                r_rb <= 1'b1;
            end else if (w_cmd_reset) begin
                r_rb   <= 1'b0;
                r_hold <= C_HOLD;
            end else if (r_hold != 3'd0) begin
                r_hold <= r_hold - 3'd1;
                if (r_hold == 3'd1) begin
                    r_rb <= 1'b1;
                end
            end

            if (w_enter_load || w_enter_prog) begin
                r_cnt <= '0;
            end else if (r_state == ST_RD_LOAD || r_state == ST_PG_BUSY) begin
                r_cnt <= r_cnt + C_CNT_1;
            end

            if (w_cmd && (w_io_in == CMD_READ || w_io_in == CMD_PROG)) begin
                r_addr_cnt <= '0;
            end else if (w_adr_take) begin
                r_addr_cnt <= r_addr_cnt + 2'd1;
                case (r_addr_cnt)
                    2'd1:    r_page[7:0]         <= w_io_in;
                    2'd2:    r_page[PAGE_AW-1:8] <= w_io_in[PAGE_AW-9:0];
                    default: ;
                endcase
            end

            if (w_adr_take && r_addr_cnt == 2'd0) begin
                r_col <= {{(COL_AW-7){1'b0}}, w_io_in};
            end else if (w_pg_wr) begin
                // Saturates past the last column so late bytes are dropped.
                r_col <= r_col + C_COL_1;
            end else if (w_ren_rise && r_state == ST_RD_OUT) begin
                r_col <= {1'b0, r_col[COL_AW-1:0] + C_COL_1[COL_AW-1:0]};
            end

            // Array data lags arr_addr by a cycle, so the load write is delayed too.
            r_ld_vld   <= (r_state == ST_RD_LOAD) && (r_cnt < C_PAGE);
            r_ld_col   <= r_cnt[COL_AW-1:0];
            // Program sweep is aligned with the page buffer's registered read port.
            r_arr_we   <= (r_state == ST_PG_BUSY) && (r_cnt < C_PAGE);
            r_prog_col <= r_cnt[COL_AW-1:0];
        end
    end

    // ---------------- page register ----------------
    always_comb begin
        w_buf_we    = r_ld_vld | w_pg_wr;
        w_buf_waddr = r_ld_vld ? r_ld_col : r_col[COL_AW-1:0];
        w_buf_wdata = r_ld_vld ? arr_rdata : w_io_in;
    end

    nft_page_buf #(
        .DEPTH (PAGE_BYTES),
        .AW    (COL_AW)
    ) u_page_buf (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_buf_we),
        .i_waddr  (w_buf_waddr),
        .i_wdata  (w_buf_wdata),
        .i_araddr (r_col[COL_AW-1:0]),
        .o_ardata (w_buf_ardata),
        .i_sraddr (r_cnt[COL_AW-1:0]),
        .o_srdata (w_buf_srdata)
    );

endmodule

// File: tb/tb_nand_flash_target.sv
// Bench for nand_flash_target: pin-level driver tasks, an array memory model,
// a write scoreboard fed from a model of the page register, and a vector table.
module tb_nand_flash_target;
    import nfc_pkg::*;

    logic        clk;
    logic        rst;
    wire  [7:0]  F_IO;
    logic        F_CLE, F_ALE, F_WEN, F_REN;
    logic        F_RB;
    logic [17:0] arr_addr;
    logic [7:0]  arr_wdata;
    logic        arr_we;
    logic [7:0]  arr_rdata;
    nfc_state_t  dbg_state;
    logic        dbg_io_oe;

    logic        tb_drv;
    logic [7:0]  tb_io;
    logic        arr_init;

    logic [7:0]  arr_mem [0:262143];
    logic [7:0]  pm [512];            // expected page-register contents
    logic [25:0] exp_q [$];           // {addr, data} expected array writes

    int n_checks;
    int n_errs;
    int n_wr;

    assign F_IO = tb_drv ? tb_io : 8'bz;

    nand_flash_target dut (
        .clk         (clk),
        .rst         (rst),
        .F_IO        (F_IO),
        .F_CLE       (F_CLE),
        .F_ALE       (F_ALE),
        .F_WEN       (F_WEN),
        .F_REN       (F_REN),
        .F_RB        (F_RB),
        .arr_addr    (arr_addr),
        .arr_wdata   (arr_wdata),
        .arr_we      (arr_we),
        .arr_rdata   (arr_rdata),
        .o_dbg_state (dbg_state),
        .o_dbg_io_oe (dbg_io_oe)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- array memory model ----------------
    always @(posedge clk) begin
        if (arr_init) begin
            for (int n = 0; n < 512; n++) begin
                arr_mem[{9'd5, 9'(n)}] <= 8'(n) ^ 8'hA5;
            end
        end else if (arr_we) begin
            arr_mem[arr_addr] <= arr_wdata;
        end
        arr_rdata <= arr_mem[arr_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- write scoreboard ----------------
    always @(negedge clk) begin
        if (arr_we === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL arr_write_unexpected: got %0h expected no write", {arr_addr, arr_wdata});
            end else begin
                check("arr_write", {6'd0, arr_addr, arr_wdata}, {6'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic bus_write(input logic cle, input logic ale, input logic [7:0] d);
        F_CLE = cle;
        F_ALE = ale;
        tb_io = d;
        tb_drv = 1'b1;
        F_WEN = 1'b0;
        @(negedge clk);
        F_WEN = 1'b1;
        @(negedge clk);
        tb_drv = 1'b0;
        F_CLE = 1'b0;
        F_ALE = 1'b0;
    endtask

    task automatic send_addr(input logic [8:0] col, input logic [8:0] page);
        bus_write(1'b0, 1'b1, col[7:0]);
        bus_write(1'b0, 1'b1, page[7:0]);
        bus_write(1'b0, 1'b1, {7'd0, page[8]});
    endtask

    task automatic read_byte(input string name, input logic [7:0] exp);
        F_REN = 1'b0;
        #1;
        check(name, {24'd0, F_IO}, {24'd0, exp});
        @(negedge clk);
        F_REN = 1'b1;
        @(negedge clk);
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (F_RB !== 1'b1 && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic       cle;
        logic       ale;
        logic [7:0] io;
        nfc_state_t st;
        logic       rb;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int cnt;
        int wr0;
        logic [7:0] pat [4];

        n_checks = 0;
        n_errs   = 0;
        n_wr     = 0;
        rst      = 1'b1;
        F_WEN    = 1'b1;
        F_REN    = 1'b1;
        F_CLE    = 1'b0;
        F_ALE    = 1'b0;
        tb_drv   = 1'b0;
        tb_io    = 8'h00;
        arr_init = 1'b1;
        repeat (3) @(negedge clk);
        arr_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // ---- reset state ----
        check("rst_rb",    {31'd0, F_RB},      32'd1);
        check("rst_io_oe", {31'd0, dbg_io_oe}, 32'd0);
        check("rst_we",    {31'd0, arr_we},    32'd0);
        check("rst_addr",  {14'd0, arr_addr},  32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

        // ---- decode table ----
        vecs[0]  = '{1'b0, 1'b0, 8'h33, ST_IDLE,    1'b1};
        vecs[1]  = '{1'b0, 1'b0, 8'hCC, ST_IDLE,    1'b1};
        vecs[2]  = '{1'b1, 1'b0, 8'h55, ST_IDLE,    1'b1};
        vecs[3]  = '{1'b1, 1'b0, 8'h80, ST_PG_ADDR, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 8'h00, ST_PG_ADDR, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'hAA, ST_IDLE,    1'b1};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, ST_RD_ADDR, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 8'h10, ST_IDLE,    1'b1};
        vecs[8]  = '{1'b1, 1'b0, 8'h80, ST_PG_ADDR, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, ST_PG_ADDR, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'h07, ST_PG_ADDR, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'h00, ST_PG_IN,   1'b1};
        vecs[12] = '{1'b1, 1'b0, 8'hFF, ST_IDLE,    1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h11, ST_IDLE,    1'b1};
        vecs[14] = '{1'b1, 1'b0, 8'h33, ST_IDLE,    1'b1};
        for (int i = 0; i < 15; i++) begin
            bus_write(vecs[i].cle, vecs[i].ale, vecs[i].io);
            check($sformatf("vec%0d_state", i), {29'd0, dbg_state}, {29'd0, vecs[i].st});
            check($sformatf("vec%0d_rb", i), {31'd0, F_RB}, {31'd0, vecs[i].rb});
            if (!vecs[i].rb) begin
                count_busy(cnt);
                check($sformatf("vec%0d_reset_busy", i), cnt, 32'd4);
            end
        end

        // ---- read page 5 ----
        bus_write(1'b1, 1'b0, CMD_READ);
        send_addr(9'd0, 9'd5);
        count_busy(cnt);
        check("read_busy_cycles", cnt, 32'd521);
        check("read_state", {29'd0, dbg_state}, {29'd0, ST_RD_OUT});
        check("read_io_idle", {31'd0, dbg_io_oe}, 32'd0);
        for (int n = 0; n < 512; n++) begin
            pm[n] = 8'(n) ^ 8'hA5;
            read_byte($sformatf("read_b%0d", n), pm[n]);
        end
        read_byte("read_wrap", 8'hA5);

        // ---- program page 0x1FF ----
        bus_write(1'b1, 1'b0, CMD_PROG);
        send_addr(9'd0, 9'h1FF);
        for (int i = 0; i < 512; i++) begin
            bus_write(1'b0, 1'b0, 8'(i));
            pm[i] = 8'(i);
            exp_q.push_back({9'h1FF, 9'(i), 8'(i)});
        end
        check("prog_state_in", {29'd0, dbg_state}, {29'd0, ST_PG_IN});
        wr0 = n_wr;
        bus_write(1'b1, 1'b0, CMD_CONFIRM);
        count_busy(cnt);
        check("prog_busy_cycles", cnt, 32'd528);
        check("prog_writes", n_wr - wr0, 32'd512);
        check("prog_queue_empty", exp_q.size(), 32'd0);
        check("prog_state_end", {29'd0, dbg_state}, {29'd0, ST_IDLE});

        // ---- partial program page 3, with 0xFF during busy ----
        pat[0] = 8'hDE; pat[1] = 8'hAD; pat[2] = 8'hBE; pat[3] = 8'hEF;
        bus_write(1'b1, 1'b0, CMD_PROG);
        send_addr(9'h010, 9'd3);
        for (int i = 0; i < 4; i++) begin
            bus_write(1'b0, 1'b0, pat[i]);
            pm[16 + i] = pat[i];
        end
        for (int c = 0; c < 512; c++) begin
            exp_q.push_back({9'd3, 9'(c), pm[c]});
        end
        wr0 = n_wr;
        bus_write(1'b1, 1'b0, CMD_CONFIRM);
        cnt = 0;
        repeat (10) begin
            if (F_RB === 1'b0) cnt++;
            @(negedge clk);
        end
        bus_write(1'b1, 1'b0, CMD_RESET);
        check("ff_busy_state", {29'd0, dbg_state}, {29'd0, ST_PG_BUSY});
        begin
            int rest;
            count_busy(rest);
            cnt = cnt + 2 + rest;
        end
        check("partial_busy_cycles", cnt, 32'd528);
        check("partial_writes", n_wr - wr0, 32'd512);
        check("partial_queue_empty", exp_q.size(), 32'd0);
        check("partial_state_end", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("partial_arr_dead", {24'd0, arr_mem[{9'd3, 9'h011}]}, 32'hAD);

        // ---- reset in the middle of a program sweep ----
        bus_write(1'b1, 1'b0, CMD_PROG);
        send_addr(9'd0, 9'd2);
        check("mid_state_in", {29'd0, dbg_state}, {29'd0, ST_PG_IN});
        for (int c = 0; c < 512; c++) begin
            exp_q.push_back({9'd2, 9'(c), pm[c]});
        end
        wr0 = n_wr;
        bus_write(1'b1, 1'b0, CMD_CONFIRM);
        cnt = 0;
        while (n_wr < wr0 + 100 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("mid_reached_100", {31'd0, (n_wr >= wr0 + 100)}, 32'd1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_rb",    {31'd0, F_RB},      32'd1);
        check("mid_rst_we",    {31'd0, arr_we},    32'd0);
        check("mid_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        rst = 1'b0;
        @(negedge clk);

        bus_write(1'b1, 1'b0, CMD_READ);
        send_addr(9'd0, 9'd5);
        count_busy(cnt);
        check("reread_busy_cycles", cnt, 32'd521);
        check("reread_state", {29'd0, dbg_state}, {29'd0, ST_RD_OUT});
        read_byte("reread_b0", 8'hA5);
        read_byte("reread_b1", 8'hA4);
        read_byte("reread_b2", 8'hA7);
        read_byte("reread_b3", 8'hA6);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
